// File: rtl/alu_scoreboard_fifo_if.sv
// alu_scoreboard_fifo_if: request/response bus between a DUT driver and the ALU scoreboard
//   master: drives req_valid/req_op/req_a/req_b and rsp_valid/rsp_result, samples req_ready
//   slave : the scoreboard, samples the request/response and drives req_ready
interface alu_scoreboard_fifo_if #(parameter int WIDTH = 8);
   logic                 req_valid;
   logic                 req_ready;
   logic [2:0]           req_op;
   logic [WIDTH-1:0]     req_a;
   logic [WIDTH-1:0]     req_b;
   logic                 rsp_valid;
   logic [2*WIDTH-1:0]   rsp_result;
   modport master (output req_valid, req_op, req_a, req_b, rsp_valid, rsp_result, input req_ready);
   modport slave  (input req_valid, req_op, req_a, req_b, rsp_valid, rsp_result, output req_ready);
endinterface

// File: rtl/alu_scoreboard_fifo.sv
// alu_scoreboard_fifo: predicts ALU results into an in-order queue and checks DUT responses against them
//   clk/reset_n  : clock, asynchronous active-low reset
//   clr          : synchronous clear of queue, counters, flags and capture
//   bus          : request (valid/ready/op/a/b) and response (valid/result) handshake
//   pass/fail/orphan_cnt : saturating statistics; err_flag sticky on mismatch or orphan
//   fail_op/exp/got      : first mismatch since reset/clr; level: queue occupancy
module alu_scoreboard_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clr,
   alu_scoreboard_fifo_if.slave       bus,
   output logic [CNT_W-1:0]           pass_cnt,
   output logic [CNT_W-1:0]           fail_cnt,
   output logic [CNT_W-1:0]           orphan_cnt,
   output logic                       err_flag,
   output logic [2:0]                 fail_op,
   output logic [2*WIDTH-1:0]         fail_exp,
   output logic [2*WIDTH-1:0]         fail_got,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int RW = 2 * WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   logic [2:0]    op_mem  [DEPTH];
   logic [RW-1:0] exp_mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [RW-1:0] a, b, pred;
   logic          push, pop, orphan, match;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
   assign a = RW'(bus.req_a);
   assign b = RW'(bus.req_b);
   always_comb
      pred = bus.req_op == 3'd1 ? a + b :
             bus.req_op == 3'd2 ? a & b :
             bus.req_op == 3'd3 ? a ^ b :
             bus.req_op == 3'd4 ? a * b :
             bus.req_op == 3'd5 ? a + (b << 1) :
             bus.req_op == 3'd6 ? a << 1 :
             bus.req_op == 3'd7 ? a + (a << 1) : '0;
   assign bus.req_ready = level != LW'(DEPTH);
   assign push   = bus.req_valid && bus.req_ready && bus.req_op != 3'd0;
   // emptiness is judged on the registered level, so a same-cycle push cannot satisfy a response
   assign pop    = bus.rsp_valid && level != '0;
   assign orphan = bus.rsp_valid && level == '0;
   assign match  = exp_mem[rd_ptr] == bus.rsp_result;
   always_ff @(posedge clk)
      if (push) begin
         op_mem[wr_ptr]  <= bus.req_op;
         exp_mem[wr_ptr] <= pred;
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n || clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         orphan_cnt <= '0;
         err_flag   <= 1'b0;
         fail_op    <= '0;
         fail_exp   <= '0;
         fail_got   <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         level  <= level + LW'(push) - LW'(pop);
         if (orphan) begin
            orphan_cnt <= sat_inc(orphan_cnt);
            err_flag   <= 1'b1;
         end
         if (pop && match)
            pass_cnt <= sat_inc(pass_cnt);
         if (pop && !match) begin
            fail_cnt <= sat_inc(fail_cnt);
            err_flag <= 1'b1;
            // a zero fail count means no mismatch has been captured since reset/clr
            if (fail_cnt == '0) begin
               fail_op  <= op_mem[rd_ptr];
               fail_exp <= exp_mem[rd_ptr];
               fail_got <= bus.rsp_result;
            end
         end
      end
endmodule

// File: tb/tb_alu_scoreboard_fifo.sv
// tb_alu_scoreboard_fifo: directed and randomized checks of alu_scoreboard_fifo against a queue-based model
module tb_alu_scoreboard_fifo;
   localparam int W = 8;
   localparam int DEPTH = 4;
   typedef struct {logic [2:0] op; logic [15:0] exp;} ent_t;
   logic clk, reset_n, clr;
   logic [15:0] pass_cnt, fail_cnt, orphan_cnt;
   logic [1:0]  s_pass, s_fail, s_orph;
   logic        err_flag, s_err;
   logic [2:0]  fail_op, s_fop;
   logic [15:0] fail_exp, fail_got, s_fexp, s_fgot;
   logic [2:0]  level, s_level;
   int n_chk = 0, n_fail = 0;
   ent_t m_q[$];
   int m_pass, m_fail, m_orph;
   bit m_err, m_cap;
   logic [2:0] m_fop;
   logic [15:0] m_fexp, m_fgot;
   alu_scoreboard_fifo_if #(.WIDTH(W)) bus();
   alu_scoreboard_fifo_if #(.WIDTH(W)) bus2();
   assign bus2.req_valid  = bus.req_valid;
   assign bus2.req_op     = bus.req_op;
   assign bus2.req_a      = bus.req_a;
   assign bus2.req_b      = bus.req_b;
   assign bus2.rsp_valid  = bus.rsp_valid;
   assign bus2.rsp_result = bus.rsp_result;
   alu_scoreboard_fifo #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .bus(bus),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .orphan_cnt(orphan_cnt), .err_flag(err_flag),
      .fail_op(fail_op), .fail_exp(fail_exp), .fail_got(fail_got), .level(level));
   alu_scoreboard_fifo #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .clr(clr), .bus(bus2),
      .pass_cnt(s_pass), .fail_cnt(s_fail), .orphan_cnt(s_orph), .err_flag(s_err),
      .fail_op(s_fop), .fail_exp(s_fexp), .fail_got(s_fgot), .level(s_level));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] predict(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int unsigned x = a, y = b, r;
      case (op)
         3'd1: r = x + y;
         3'd2: r = x & y;
         3'd3: r = x ^ y;
         3'd4: r = x * y;
         3'd5: r = x + 2 * y;
         3'd6: r = 2 * x;
         3'd7: r = 3 * x;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction
   function automatic int sat(input int v, input int mx);
      return v > mx ? mx : v;
   endfunction
   task automatic model_clear();
      m_q.delete();
      m_pass = 0; m_fail = 0; m_orph = 0;
      m_err = 0; m_cap = 0;
      m_fop = 0; m_fexp = 0; m_fgot = 0;
   endtask
   task automatic compare_all();
      chk("level", level, m_q.size());
      chk("ready", bus.req_ready, m_q.size() != DEPTH);
      chk("pass_cnt", pass_cnt, m_pass);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("orphan_cnt", orphan_cnt, m_orph);
      chk("err_flag", err_flag, m_err);
      chk("fail_op", fail_op, m_fop);
      chk("fail_exp", fail_exp, m_fexp);
      chk("fail_got", fail_got, m_fgot);
      chk("sat_pass", s_pass, sat(m_pass, 3));
      chk("sat_fail", s_fail, sat(m_fail, 3));
      chk("sat_orphan", s_orph, sat(m_orph, 3));
   endtask
   task automatic step(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit rv, input logic [15:0] r, input bit c);
      bit rdy;
      ent_t e;
      bus.req_valid = v; bus.req_op = op; bus.req_a = a; bus.req_b = b;
      bus.rsp_valid = rv; bus.rsp_result = r; clr = c;
      rdy = m_q.size() != DEPTH;
      #1;
      chk("ready_pre", bus.req_ready, rdy);
      if (c) model_clear();
      else begin
         if (rv) begin
            if (m_q.size() == 0) begin
               m_orph++;
               m_err = 1;
            end else begin
               e = m_q.pop_front();
               if (e.exp == r) m_pass++;
               else begin
                  m_fail++;
                  m_err = 1;
                  if (!m_cap) begin
                     m_cap = 1; m_fop = e.op; m_fexp = e.exp; m_fgot = r;
                  end
               end
            end
         end
         if (v && rdy && op != 3'd0) begin
            e.op = op;
            e.exp = predict(op, a, b);
            m_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask
   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic rsp_head();
      step(0, 0, 0, 0, 1, m_q.size() > 0 ? m_q[0].exp : 16'h0, 0);
   endtask
   initial begin
      logic [15:0] r;
      reset_n = 0; clr = 0;
      bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
      bus.rsp_valid = 0; bus.rsp_result = 0;
      model_clear();
      #12;
      compare_all();
      @(posedge clk); #1;
      reset_n = 1;
      // add FF+01
      step(1, 3'd1, 8'hFF, 8'h01, 0, 0, 0);
      step(0, 0, 0, 0, 1, 16'h0100, 0);
      chk("add_pass", pass_cnt, 1);
      chk("add_err", err_flag, 0);
      chk("add_level", level, 0);
      // mul FF*FF with wrong response, then a second mismatch
      step(1, 3'd4, 8'hFF, 8'hFF, 0, 0, 0);
      step(0, 0, 0, 0, 1, 16'hFE00, 0);
      chk("mul_fail", fail_cnt, 1);
      chk("mul_err", err_flag, 1);
      chk("mul_fop", fail_op, 3'b100);
      chk("mul_fexp", fail_exp, 16'hFE01);
      chk("mul_fgot", fail_got, 16'hFE00);
      step(1, 3'd1, 8'h01, 8'h01, 0, 0, 0);
      step(0, 0, 0, 0, 1, 16'h0000, 0);
      chk("cap_keep_exp", fail_exp, 16'hFE01);
      chk("cap_keep_fop", fail_op, 3'b100);
      // no_op is dropped
      step(1, 3'd0, 8'h12, 8'h34, 0, 0, 0);
      chk("noop_level", level, 0);
      // fill queue, 5th ignored, drain in order
      step(1, 3'd1, 8'h01, 8'h02, 0, 0, 0);
      step(1, 3'd3, 8'hA5, 8'h0F, 0, 0, 0);
      step(1, 3'd5, 8'h10, 8'h80, 0, 0, 0);
      step(1, 3'd6, 8'hC3, 8'h00, 0, 0, 0);
      chk("full_level", level, 4);
      chk("full_ready", bus.req_ready, 0);
      step(1, 3'd4, 8'h02, 8'h03, 0, 0, 0);
      chk("full_ignore", level, 4);
      step(0, 0, 0, 0, 1, 16'h0003, 0);
      step(0, 0, 0, 0, 1, 16'h00AA, 0);
      step(0, 0, 0, 0, 1, 16'h0110, 0);
      step(0, 0, 0, 0, 1, 16'h0186, 0);
      chk("drain_pass", pass_cnt, 5);
      // orphan at empty with same-cycle push
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 3'd7, 8'h05, 8'h00, 1, 16'h000F, 0);
      chk("orph_cnt", orphan_cnt, 1);
      chk("orph_level", level, 1);
      step(0, 0, 0, 0, 1, 16'h000F, 0);
      chk("orph_pass", pass_cnt, 1);
      // clr beats push/pop on a full queue
      for (int i = 0; i < 4; i++) step(1, 3'd2, 8'($urandom), 8'($urandom), 0, 0, 0);
      step(1, 3'd1, 8'h01, 8'h01, 1, 16'h1234, 1);
      chk("clr_level", level, 0);
      chk("clr_err", err_flag, 0);
      chk("clr_orph", orphan_cnt, 0);
      // saturation of the narrow counters
      for (int i = 0; i < 5; i++) begin
         step(1, 3'd1, 8'($urandom), 8'($urandom), 0, 0, 0);
         rsp_head();
      end
      chk("sat3", s_pass, 2'd3);
      chk("sat_wide", pass_cnt, 5);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         r = (m_q.size() > 0 && $urandom_range(4) != 0) ? m_q[0].exp : 16'($urandom);
         step($urandom_range(1) == 1, 3'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(2) == 0, r, $urandom_range(80) == 0);
      end
      // asynchronous reset mid-stream
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 3'd1, 8'h11, 8'h22, 0, 0, 0);
      step(1, 3'd3, 8'h33, 8'h44, 1, 16'h0033, 0);
      step(1, 3'd4, 8'h55, 8'h66, 1, 16'hBEEF, 0);
      bus.req_valid = 0; bus.rsp_valid = 0;
      #2;
      reset_n = 0;
      #1;
      model_clear();
      compare_all();
      chk("rst_level", level, 0);
      chk("rst_err", err_flag, 0);
      @(posedge clk); #1;
      compare_all();
      reset_n = 1;
      step(0, 0, 0, 0, 1, 16'h0099, 0);
      chk("post_rst_orph", orphan_cnt, 1);
      idle();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_scoreboard_fifo.md
ALU_SCOREBOARD_FIFO -- requirements
Module: alu_scoreboard_fifo

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (min 4).
REQ-002 Parameter DEPTH, default 4, expected-result queue entries (power of two, min 2).
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port clr  input  1  synchronous clear of queue, counters, flags.
REQ-007 Port req_valid  input  1  operation issued to DUT this cycle.
REQ-008 Port req_ready  output  1  scoreboard can accept a request.
REQ-009 Port req_op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101 sp_func1, 110 sp_func2, 111 sp_func3.
REQ-010 Port req_a, req_b  input  WIDTH  operands.
REQ-011 Port rsp_valid  input  1  DUT done pulse, one per non-no_op request.
REQ-012 Port rsp_result  input  2*WIDTH  DUT result.
REQ-013 Port pass_cnt, fail_cnt, orphan_cnt  output  CNT_W  statistics.
REQ-014 Port err_flag  output  1  sticky: any mismatch or orphan since reset/clr.
REQ-015 Port fail_op  output  3; fail_exp, fail_got  output  2*WIDTH  first-mismatch capture.
REQ-016 Port level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-017 Prediction, all modulo 2^(2*WIDTH), operands zero-extended: add A+B; and A&B; xor A^B; mul A*B; sp_func1 A+2*B; sp_func2 2*A; sp_func3 3*A.
REQ-018 req_ready SHALL equal (level != DEPTH); a request is accepted when req_valid and req_ready are both high.
REQ-019 Accepted non-no_op request SHALL push {op, predicted} at tail; accepted no_op SHALL be dropped, with no push and no counter change.
REQ-020 rsp_valid with level != 0 SHALL pop the head and compare head.predicted to rsp_result in the same cycle.
REQ-021 Compare outcome SHALL register on that edge: match increments pass_cnt; mismatch increments fail_cnt and sets err_flag.
REQ-022 First mismatch after reset/clr SHALL load fail_op/fail_exp/fail_got; later mismatches SHALL not overwrite them.
REQ-023 rsp_valid with level == 0 (evaluated before any same-cycle push) SHALL increment orphan_cnt, set err_flag, and pop nothing.
REQ-024 Simultaneous accepted push and pop SHALL leave level unchanged, with FIFO order preserved and pointers wrapping modulo DEPTH.
REQ-025 A push when full cannot occur (req_ready low); req_valid while full SHALL be ignored.
REQ-026 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 clr SHALL take priority over same-cycle push/pop: the queue empties, counters and flags zero, captures clear, and the next cycle operates normally.
REQ-028 level SHALL be registered; req_ready is a combinational decode of level only.

Reset
REQ-029 reset_n low SHALL asynchronously force: level 0, pointers 0, req_ready 1, all counters 0, err_flag 0, fail_op/fail_exp/fail_got 0.
REQ-030 Reset asserted mid-operation SHALL discard all queued predictions; responses after reset release with an empty queue count as orphans.
REQ-031 Outputs SHALL remain at reset values until the first clk edge after reset_n deasserts.

Verification
REQ-032 WIDTH=8: push add A=FF B=01, then rsp 0100 -> pass_cnt=1, err_flag=0, level=0.
REQ-033 Push mul FF*FF, then rsp FE00 -> fail_cnt=1, err_flag=1, fail_op=100, fail_exp=FE01, fail_got=FE00; a second mismatch leaves the capture unchanged.
REQ-034 DEPTH=4: push 4 ops without responses -> level=4, req_ready=0; a 5th req_valid is ignored; 4 correct rsps -> pass_cnt=4 in order.
REQ-035 level=0 with same-cycle push sp_func3 A=05 and rsp_valid -> orphan_cnt=1, level=1; next rsp 000F -> pass_cnt=1.
REQ-036 Full queue: pulse clr with rsp_valid high -> level=0, all counters 0, err_flag 0; assert reset_n low mid-stream -> all outputs at reset values immediately.
REQ-037 CNT_W=2: 5 passing transactions -> pass_cnt saturates at 3.
